// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit_pkg
//  Description : Shared operation codes, state encodings and op-class helpers
//                for the iterative RV32M multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_unit_pkg;

    // ALU SELECT codes (shared encoding with the single-cycle ALU)
    localparam logic [4:0] c_sel_mul    = 5'b01011;
    localparam logic [4:0] c_sel_mulh   = 5'b01100;
    localparam logic [4:0] c_sel_mulhsu = 5'b01101;
    localparam logic [4:0] c_sel_mulhu  = 5'b01110;
    localparam logic [4:0] c_sel_div    = 5'b01111;
    localparam logic [4:0] c_sel_divu   = 5'b10000;
    localparam logic [4:0] c_sel_rem    = 5'b10001;
    localparam logic [4:0] c_sel_remu   = 5'b10010;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_prep = 3'd1;
    localparam logic [2:0] c_st_calc = 3'd2;
    localparam logic [2:0] c_st_fix  = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;

    function automatic logic sel_valid(input logic [4:0] sel);
        return (sel >= c_sel_mul) && (sel <= c_sel_remu);
    endfunction

    function automatic logic sel_is_mul(input logic [4:0] sel);
        return (sel >= c_sel_mul) && (sel <= c_sel_mulhu);
    endfunction

    function automatic logic sel_signed_a(input logic [4:0] sel);
        return (sel == c_sel_mul) || (sel == c_sel_mulh) || (sel == c_sel_mulhsu) ||
               (sel == c_sel_div) || (sel == c_sel_rem);
    endfunction

    function automatic logic sel_signed_b(input logic [4:0] sel);
        return (sel == c_sel_mul) || (sel == c_sel_mulh) ||
               (sel == c_sel_div) || (sel == c_sel_rem);
    endfunction

    function automatic logic sel_is_rem(input logic [4:0] sel);
        return (sel == c_sel_rem) || (sel == c_sel_remu);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_negate.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit_negate
//  Description : Conditional two's-complement negation, parameterised width.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_negate,
    output logic [WIDTH-1:0] o_value
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    assign o_value = i_negate ? ((~i_value) + c_one) : i_value;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV32M multiply/divide unit with start/busy/done
//                handshake; shift-add multiply, restoring divide.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [4:0]      SELECT,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    localparam int                c_cnt_w   = $clog2(ITER + 1);
    localparam logic [c_cnt_w-1:0] c_iter    = c_cnt_w'(ITER);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [XLEN-1:0]    c_min_neg = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [4:0]         r_op;
    logic [XLEN-1:0]    r_data1;
    logic [XLEN-1:0]    r_data2;
    logic [XLEN-1:0]    r_opb;
    logic [2*XLEN-1:0]  r_prod;
    logic [XLEN-1:0]    r_quot;
    logic [XLEN-1:0]    r_rem;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_special;
    logic [XLEN-1:0]    r_spec_val;
    logic               r_busy;
    logic               r_done;
    logic [XLEN-1:0]    r_result;

    logic               w_is_mul;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [XLEN-1:0]    w_mag_a;
    logic [XLEN-1:0]    w_mag_b;
    logic               w_div0;
    logic               w_ovf;
    logic [XLEN-1:0]    w_spec_val;
    logic [XLEN:0]      w_sum;
    logic [XLEN:0]      w_shift;
    logic               w_ge;
    logic [XLEN-1:0]    w_diff;
    logic [2*XLEN-1:0]  w_prod_fix;
    logic [XLEN-1:0]    w_quot_fix;
    logic [XLEN-1:0]    w_rem_fix;
    logic [XLEN-1:0]    w_fix_val;

    assign w_is_mul = sel_is_mul(r_op);
    assign w_neg_a  = sel_signed_a(r_op) & r_data1[XLEN-1];
    assign w_neg_b  = sel_signed_b(r_op) & r_data2[XLEN-1];

    muldiv_unit_negate #(.WIDTH(XLEN)) u_mag_a (
        .i_value (r_data1),
        .i_negate(w_neg_a),
        .o_value (w_mag_a)
    );

    muldiv_unit_negate #(.WIDTH(XLEN)) u_mag_b (
        .i_value (r_data2),
        .i_negate(w_neg_b),
        .o_value (w_mag_b)
    );

    // Divide corner cases resolved in PREP so CALC can be skipped entirely
    assign w_div0 = (r_data2 == '0);
    assign w_ovf  = ((r_op == c_sel_div) || (r_op == c_sel_rem)) &&
                    (r_data1 == c_min_neg) && (r_data2 == '1);

    always_comb begin
        w_spec_val = '0;
        if (w_div0) begin
            w_spec_val = sel_is_rem(r_op) ? r_data1 : '1;
        end else if (w_ovf) begin
            w_spec_val = sel_is_rem(r_op) ? '0 : c_min_neg;
        end
    end

    assign w_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, (r_prod[0] ? r_opb : '0)};
    assign w_shift = {r_rem, r_quot[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, r_opb});
    // Partial remainder stays below the divisor, so the low bits hold the exact difference
    assign w_diff  = w_shift[XLEN-1:0] - r_opb;

    muldiv_unit_negate #(.WIDTH(2*XLEN)) u_fix_p (
        .i_value (r_prod),
        .i_negate(r_neg_q),
        .o_value (w_prod_fix)
    );

    muldiv_unit_negate #(.WIDTH(XLEN)) u_fix_q (
        .i_value (r_quot),
        .i_negate(r_neg_q),
        .o_value (w_quot_fix)
    );

    muldiv_unit_negate #(.WIDTH(XLEN)) u_fix_r (
        .i_value (r_rem),
        .i_negate(r_neg_r),
        .o_value (w_rem_fix)
    );

    always_comb begin
        w_fix_val = w_quot_fix;
        case (r_op)
            c_sel_mul:                          w_fix_val = w_prod_fix[XLEN-1:0];
            c_sel_mulh, c_sel_mulhsu, c_sel_mulhu: w_fix_val = w_prod_fix[2*XLEN-1:XLEN];
            c_sel_rem, c_sel_remu:              w_fix_val = w_rem_fix;
            default:                            w_fix_val = w_quot_fix;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_op       <= '0;
            r_data1    <= '0;
            r_data2    <= '0;
            r_opb      <= '0;
            r_prod     <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_special  <= 1'b0;
            r_spec_val <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (START && sel_valid(SELECT)) begin
                        r_op    <= SELECT;
                        r_data1 <= DATA1;
                        r_data2 <= DATA2;
                        r_busy  <= 1'b1;
                        r_state <= c_st_prep;
                    end
                end
                c_st_prep: begin
                    r_neg_q    <= w_neg_a ^ w_neg_b;
                    r_neg_r    <= w_neg_a;
                    r_cnt      <= c_iter;
                    r_special  <= !w_is_mul && (w_div0 || w_ovf);
                    r_spec_val <= w_spec_val;
                    if (w_is_mul) begin
                        r_opb  <= w_mag_a;
                        r_prod <= {{XLEN{1'b0}}, w_mag_b};
                    end else begin
                        r_opb  <= w_mag_b;
                        r_quot <= w_mag_a;
                        r_rem  <= '0;
                    end
                    r_state <= (!w_is_mul && (w_div0 || w_ovf)) ? c_st_fix : c_st_calc;
                end
                c_st_calc: begin
                    r_cnt <= r_cnt - c_cnt_one;
                    if (w_is_mul) begin
                        r_prod <= {w_sum, r_prod[XLEN-1:1]};
                    end else begin
                        r_quot <= {r_quot[XLEN-2:0], w_ge};
                        r_rem  <= w_ge ? w_diff : w_shift[XLEN-1:0];
                    end
                    if (r_cnt == c_cnt_one) begin
                        r_state <= c_st_fix;
                    end
                end
                c_st_fix: begin
                    r_result <= r_special ? r_spec_val : w_fix_val;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= c_st_done;
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign BUSY   = r_busy;
    assign DONE   = r_done;
    assign RESULT = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Directed and random self-checking bench for muldiv_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam logic [4:0] T_MUL    = 5'b01011;
    localparam logic [4:0] T_MULH   = 5'b01100;
    localparam logic [4:0] T_MULHSU = 5'b01101;
    localparam logic [4:0] T_MULHU  = 5'b01110;
    localparam logic [4:0] T_DIV    = 5'b01111;
    localparam logic [4:0] T_DIVU   = 5'b10000;
    localparam logic [4:0] T_REM    = 5'b10001;
    localparam logic [4:0] T_REMU   = 5'b10010;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [4:0]  SELECT;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .START (START),
        .SELECT(SELECT),
        .DATA1 (DATA1),
        .DATA2 (DATA2),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .RESULT(RESULT)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference results straight from the RV32M definitions using wide arithmetic
    function automatic logic [31:0] ref_result(input logic [4:0] sel, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa64;
        logic signed [63:0] sb64;
        logic signed [63:0] ub64;
        logic [63:0]        up;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa   = a;
        sb   = b;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        ub64 = {32'b0, b};
        case (sel)
            T_MUL:    return a * b;
            T_MULH:   begin up = sa64 * sb64; return up[63:32]; end
            T_MULHSU: begin up = sa64 * ub64; return up[63:32]; end
            T_MULHU:  begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            T_DIV: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            T_DIVU: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            T_REM: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            T_REMU:   return (b == 32'h0) ? a : a % b;
            default:  return 32'h0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [4:0] sel, input logic [31:0] a,
                                       input logic [31:0] b);
        bit is_div;
        bit ovf;
        is_div = (sel == T_DIV) || (sel == T_DIVU) || (sel == T_REM) || (sel == T_REMU);
        ovf    = ((sel == T_DIV) || (sel == T_REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        return (is_div && (b == 32'h0 || ovf)) ? 3 : 35;
    endfunction

    // Latency counts edges with the accepting edge as edge 1
    task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input bit scramble);
        logic [31:0] exp;
        int          exp_lat;
        int          lat;
        int          busy_err;
        bit          seen;
        exp      = ref_result(sel, a, b);
        exp_lat  = ref_latency(sel, a, b);
        busy_err = 0;
        seen     = 1'b0;
        @(negedge CLK);
        SELECT = sel;
        DATA1  = a;
        DATA2  = b;
        START  = 1'b1;
        tick();
        lat   = 1;
        START = 1'b0;
        if (scramble) begin
            DATA1  = $urandom;
            DATA2  = $urandom;
            SELECT = T_MUL;
            START  = 1'b1;
        end
        while (!seen && lat < 60) begin
            if (DONE) begin
                seen = 1'b1;
            end else begin
                if (BUSY !== 1'b1) busy_err++;
                tick();
                lat++;
                if (lat >= 2) START = 1'b0;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_run"}, 32'(busy_err), 32'd0);
        check({tag, "_busy_done"}, {31'b0, BUSY}, 32'd0);
        check({tag, "_result"}, RESULT, exp);
        tick();
        check({tag, "_pulse"}, {31'b0, DONE}, 32'd0);
        check({tag, "_hold"}, RESULT, exp);
        tick();
        tick();
        check({tag, "_idle"}, {30'b0, BUSY, DONE}, 32'd0);
    endtask

    initial begin
        logic [4:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        int          done_cnt;

        RESET  = 1'b1;
        START  = 1'b0;
        SELECT = 5'b0;
        DATA1  = 32'h0;
        DATA2  = 32'h0;
        tick();
        tick();
        check("reset_busy", {31'b0, BUSY}, 32'd0);
        check("reset_done", {31'b0, DONE}, 32'd0);
        check("reset_result", RESULT, 32'h0);
        RESET = 1'b0;
        tick();

        run_op(T_MUL, 32'd10, 32'd20, "mul_10x20", 1'b1);
        run_op(T_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_m1", 1'b0);
        run_op(T_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_m1", 1'b0);
        run_op(T_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1", 1'b0);
        run_op(T_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_m1", 1'b0);
        run_op(T_MUL, 32'h1234_5678, 32'h0, "mul_zero", 1'b0);
        run_op(T_DIV, 32'hFFFF_FFEC, 32'd3, "div_m20_3", 1'b0);
        run_op(T_REM, 32'hFFFF_FFEC, 32'd3, "rem_m20_3", 1'b0);
        run_op(T_DIVU, 32'hFFFF_FFEC, 32'd3, "divu_m20_3", 1'b0);
        run_op(T_REMU, 32'hFFFF_FFEC, 32'd3, "remu_m20_3", 1'b0);
        run_op(T_DIVU, 32'd20, 32'd0, "divu_by0", 1'b1);
        run_op(T_REMU, 32'd20, 32'd0, "remu_by0", 1'b0);
        run_op(T_DIV, 32'hFFFF_FFEC, 32'd0, "div_by0", 1'b0);
        run_op(T_REM, 32'hFFFF_FFEC, 32'd0, "rem_by0", 1'b0);
        run_op(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0);
        run_op(T_REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 1'b0);
        run_op(T_DIV, 32'h8000_0000, 32'd1, "div_min_1", 1'b0);
        run_op(T_MULH, 32'h8000_0000, 32'h8000_0000, "mulh_min", 1'b0);

        // Unsupported code must not start an operation
        @(negedge CLK);
        SELECT = 5'b00001;
        DATA1  = 32'd5;
        DATA2  = 32'd6;
        START  = 1'b1;
        tick();
        START = 1'b0;
        check("badsel_busy0", {31'b0, BUSY}, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (DONE) done_cnt++;
            tick();
        end
        check("badsel_nodone", 32'(done_cnt), 32'd0);
        check("badsel_busy1", {31'b0, BUSY}, 32'd0);

        // Reset in the middle of a divide abandons it
        @(negedge CLK);
        SELECT = T_DIV;
        DATA1  = 32'd1000;
        DATA2  = 32'd7;
        START  = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        check("rst_mid_busy_pre", {31'b0, BUSY}, 32'd1);
        RESET = 1'b1;
        tick();
        check("rst_mid_busy", {31'b0, BUSY}, 32'd0);
        check("rst_mid_done", {31'b0, DONE}, 32'd0);
        check("rst_mid_result", RESULT, 32'h0);
        RESET = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (DONE || BUSY) done_cnt++;
            tick();
        end
        check("rst_mid_quiet", 32'(done_cnt), 32'd0);
        run_op(T_MUL, 32'd7, 32'd6, "mul_7x6", 1'b0);

        for (int i = 0; i < 40; i++) begin
            sel = 5'(11 + $urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            if (i % 5 == 1) b = 32'($urandom_range(1, 15));
            if (i % 9 == 4) b = 32'h0;
            if (i % 11 == 6) a = 32'h8000_0000;
            run_op(sel, a, b, $sformatf("rand%0d", i), i % 3 == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
